// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: scheduler state encoding,
// frame timing and command limits.
package uart_pkg;

  // baud_clk cycles the transmit FIFO needs to shift one frame
  localparam int FRAME_CYCLES = 11;

  // Largest burst a single command may request (matches transmit FIFO depth)
  localparam int MAX_LEN = 16;

  // Data byte plus parity bit as stored in the transmit FIFO
  localparam int FRAME_WIDTH = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_PUSH    = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/parity_gen.sv
// Single-byte parity generator shared by the transmit and receive paths.
// Even mode returns the XOR of the byte, odd mode returns its complement.
module parity_gen (
  input  logic [7:0] i_data,
  input  logic       i_odd,
  output logic       o_parity
);

  assign o_parity = (^i_data) ^ i_odd;

endmodule

// File: rtl/sram_tx_scheduler.sv
// Reads a burst of bytes from SRAM, tags each with a parity bit and pushes
// them into the UART transmit FIFO, then enables transmission long enough
// for the whole burst to be shifted out.
module sram_tx_scheduler #(
  parameter int FRAME_CYCLES = 11,
  parameter int MAX_LEN      = 16
) (
  input  logic       baud_clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_addr,
  input  logic [4:0] cmd_len,
  input  logic       parity_odd,
  input  logic       abort,
  output logic       sram_en,
  output logic [7:0] sram_addr,
  input  logic [7:0] sram_rdata,
  output logic [7:0] fifo_data,
  output logic       fifo_parity,
  output logic       fifo_wr,
  input  logic       fifo_full,
  output logic       tx_start_n,
  output logic       busy,
  output logic       done,
  output logic       err
);

  import uart_pkg::*;

  localparam logic [7:0] LP_FRAME8 = 8'(FRAME_CYCLES);

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_addr;
  logic [4:0] r_len;
  logic [4:0] r_remain;
  logic       r_parityOdd;
  logic [7:0] r_fifoData;
  logic       r_fifoParity;
  logic [7:0] r_drainCnt;

  logic       w_lenOk;
  logic       w_accept;
  logic       w_parity;
  logic [7:0] w_drainLoad;

  // A command is legal only for 1..MAX_LEN bytes; abort always blocks acceptance
  assign w_lenOk     = (cmd_len != 5'd0) && (int'(cmd_len) <= MAX_LEN);
  assign w_accept    = (r_state == ST_IDLE) && cmd_valid && !abort && w_lenOk;
  assign w_drainLoad = {3'b000, r_len} * LP_FRAME8;

  parity_gen u_parity (
    .i_data   (sram_rdata),
    .i_odd    (r_parityOdd),
    .o_parity (w_parity)
  );

  assign fifo_data   = r_fifoData;
  assign fifo_parity = r_fifoParity;

  // State register
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state selection; abort pulls any active burst straight back to idle
  always_comb begin
    w_nextState = r_state;
    if (abort && (r_state != ST_IDLE)) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_nextState = ST_READ;
          end
        end
        ST_READ:    w_nextState = ST_CAPTURE;
        ST_CAPTURE: w_nextState = ST_PUSH;
        ST_PUSH: begin
          if (!fifo_full) begin
            w_nextState = (r_remain == 5'd1) ? ST_DRAIN : ST_READ;
          end
        end
        ST_DRAIN: begin
          if (r_drainCnt <= 8'd1) begin
            w_nextState = ST_DONE;
          end
        end
        ST_DONE:    w_nextState = ST_IDLE;
        default:    w_nextState = ST_IDLE;
      endcase
    end
  end

  // Output decode from the current state
  always_comb begin
    cmd_ready  = (r_state == ST_IDLE) && !abort;
    busy       = (r_state != ST_IDLE);
    sram_en    = (r_state == ST_READ);
    sram_addr  = (r_state == ST_READ) ? r_addr : 8'h00;
    fifo_wr    = (r_state == ST_PUSH) && !fifo_full && !abort;
    tx_start_n = (r_state != ST_DRAIN);
    done       = (r_state == ST_DONE) && !abort;
    err        = (r_state == ST_IDLE) && cmd_valid && !abort && !w_lenOk;
  end

  // Burst bookkeeping: command latch, byte capture, address/remaining and drain timer
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      r_addr       <= 8'h00;
      r_len        <= 5'd0;
      r_remain     <= 5'd0;
      r_parityOdd  <= 1'b0;
      r_fifoData   <= 8'h00;
      r_fifoParity <= 1'b0;
      r_drainCnt   <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr      <= cmd_addr;
            r_len       <= cmd_len;
            r_remain    <= cmd_len;
            r_parityOdd <= parity_odd;
          end
        end
        ST_CAPTURE: begin
          if (!abort) begin
            r_fifoData   <= sram_rdata;
            r_fifoParity <= w_parity;
          end
        end
        ST_PUSH: begin
          if (!abort && !fifo_full) begin
            r_addr   <= r_addr + 8'd1;
            r_remain <= r_remain - 5'd1;
            if (r_remain == 5'd1) begin
              r_drainCnt <= w_drainLoad;
            end
          end
        end
        ST_DRAIN: begin
          if (!abort && (r_drainCnt != 8'h00)) begin
            r_drainCnt <= r_drainCnt - 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_tx_scheduler.sv
// Bench for sram_tx_scheduler: directed bursts followed by random traffic,
// checked against a timeline model of when each read, write, drain window
// and completion pulse should occur.
module tb_sram_tx_scheduler;

  localparam int FRAME = 11;
  localparam int MAXL  = 16;

  logic       baud_clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_addr = 8'h00;
  logic [4:0] cmd_len = 5'd0;
  logic       parity_odd = 1'b0;
  logic       abort = 1'b0;
  logic       sram_en;
  logic [7:0] sram_addr;
  logic [7:0] sram_rdata;
  logic [7:0] fifo_data;
  logic       fifo_parity;
  logic       fifo_wr;
  logic       fifo_full = 1'b0;
  logic       tx_start_n;
  logic       busy;
  logic       done;
  logic       err;

  logic [7:0] mem [256];

  int total = 0;
  int bad   = 0;

  // Timeline model state
  int         cyc = 0;
  bit         act = 0;
  bit         draining = 0;
  int         readCyc;
  int         dueCyc;
  int         bytesLeft;
  int         mLen;
  logic [7:0] mAddr;
  bit         mOdd;
  int         drainStart;
  int         drainEnd;
  int         doneCyc;

  sram_tx_scheduler dut (
    .baud_clk    (baud_clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .parity_odd  (parity_odd),
    .abort       (abort),
    .sram_en     (sram_en),
    .sram_addr   (sram_addr),
    .sram_rdata  (sram_rdata),
    .fifo_data   (fifo_data),
    .fifo_parity (fifo_parity),
    .fifo_wr     (fifo_wr),
    .fifo_full   (fifo_full),
    .tx_start_n  (tx_start_n),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 baud_clk = ~baud_clk;

  // Behavioural SRAM: data appears the cycle after the read strobe
  always @(posedge baud_clk) begin
    if (sram_en) sram_rdata <= mem[sram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_sram_en", sram_en, 1'b0);
    checkOutput("rst_sram_addr", sram_addr, 8'h00);
    checkOutput("rst_fifo_wr", fifo_wr, 1'b0);
    checkOutput("rst_fifo_data", fifo_data, 8'h00);
    checkOutput("rst_fifo_parity", fifo_parity, 1'b0);
    checkOutput("rst_tx_start_n", tx_start_n, 1'b1);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [4:0] l,
                               input logic o, input logic ab, input logic f);
    bit         legal;
    bit         eWr;
    bit         eRead;
    bit         eTx;
    bit         eDone;
    bit         atDue;
    logic [7:0] eByte;
    @(negedge baud_clk);
    cmd_valid  = v;
    cmd_addr   = a;
    cmd_len    = l;
    parity_odd = o;
    abort      = ab;
    fifo_full  = f;
    #1;
    legal = (l != 5'd0) && (int'(l) <= MAXL);
    atDue = act && !draining && (cyc == dueCyc);
    eRead = act && !draining && (cyc == readCyc);
    eWr   = atDue && !f && !ab;
    eTx   = act && draining && (cyc >= drainStart) && (cyc <= drainEnd);
    eDone = act && draining && (cyc == doneCyc) && !ab;
    checkOutput("busy", busy, act);
    checkOutput("cmd_ready", cmd_ready, !act && !ab);
    checkOutput("err", err, !act && v && !ab && !legal);
    checkOutput("sram_en", sram_en, eRead);
    checkOutput("sram_addr", sram_addr, eRead ? mAddr : 8'h00);
    checkOutput("fifo_wr", fifo_wr, eWr);
    checkOutput("tx_start_n", tx_start_n, !eTx);
    checkOutput("done", done, eDone);
    if (atDue) begin
      eByte = mem[mAddr];
      checkOutput("fifo_data", fifo_data, eByte);
      checkOutput("fifo_parity", fifo_parity, (^eByte) ^ mOdd);
    end
    if (act && ab) begin
      act = 0;
    end else if (act) begin
      if (atDue) begin
        if (f) begin
          dueCyc++;
        end else begin
          mAddr = mAddr + 8'd1;
          bytesLeft--;
          if (bytesLeft == 0) begin
            draining   = 1;
            drainStart = cyc + 1;
            drainEnd   = cyc + mLen * FRAME;
            doneCyc    = drainEnd + 1;
          end else begin
            readCyc = cyc + 1;
            dueCyc  = cyc + 3;
          end
        end
      end else if (draining && (cyc == doneCyc)) begin
        act = 0;
      end
    end else if (v && !ab && legal) begin
      act       = 1;
      draining  = 0;
      mAddr     = a;
      mOdd      = o;
      bytesLeft = int'(l);
      mLen      = int'(l);
      readCyc   = cyc + 1;
      dueCyc    = cyc + 3;
    end
    cyc++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle, outputs must clear at once
  task automatic applyReset();
    @(negedge baud_clk);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    fifo_full = 1'b0;
    #1 rst = 1'b1;
    #1 checkResetValues();
    @(negedge baud_clk);
    rst = 1'b0;
    act = 0;
    cyc += 2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h01;
    mem[8'h11] = 8'h03;
    mem[8'h12] = 8'hFF;
    mem[8'h40] = 8'h00;

    // Held in reset from time zero
    @(negedge baud_clk);
    #1 checkResetValues();
    @(negedge baud_clk);
    rst = 1'b0;

    // Three-byte even burst; a competing command during the burst is ignored
    applyStimulus(1'b1, 8'h10, 5'd3, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 48; k++) applyStimulus(k < 5, 8'h55, 5'd2, 1'b1, 1'b0, 1'b0);

    // Illegal lengths
    applyStimulus(1'b1, 8'h20, 5'd0, 1'b0, 1'b0, 1'b0);
    idleCycles(2);
    applyStimulus(1'b1, 8'h20, 5'd17, 1'b0, 1'b0, 1'b0);
    idleCycles(2);

    // Address wrap
    applyStimulus(1'b1, 8'hFE, 5'd4, 1'b0, 1'b0, 1'b0);
    idleCycles(62);

    // FIFO full for five cycles during the second push
    for (int k = 0; k < 50; k++)
      applyStimulus(k == 0, 8'h20, 5'd3, 1'b0, 1'b0, (k >= 6) && (k < 11));

    // Odd parity on a zero byte
    applyStimulus(1'b1, 8'h40, 5'd1, 1'b1, 1'b0, 1'b0);
    idleCycles(18);

    // Abort during drain
    for (int k = 0; k < 20; k++)
      applyStimulus(k == 0, 8'h30, 5'd1, 1'b0, k == 8, 1'b0);

    // Abort together with a command in idle
    applyStimulus(1'b1, 8'h30, 5'd2, 1'b0, 1'b1, 1'b0);
    idleCycles(2);

    // Reset during the first push
    applyStimulus(1'b1, 8'h50, 5'd2, 1'b0, 1'b0, 1'b0);
    idleCycles(2);
    applyReset();
    idleCycles(8);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 2) == 0, 8'($urandom), 5'($urandom_range(0, 18)),
                    1'($urandom), $urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0);
    end
    idleCycles(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
